// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// State encoding and operation select values.
package serial_add_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_bit_full_adder.sv
// Single-bit full adder cell used by the serial datapath.
// Purely combinational.
module bit_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   // sum and carry of one bit position
   always_comb begin
      s    = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial N-bit adder/subtractor, LSB first, one bit per clock.
// Subtract is a + ~b + 1 with the +1 entering through the carry flop.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             c_q;
   logic             carry_q;
   logic             ovf_q;
   logic             ready_q;
   logic             done_q;
   logic             fa_s;
   logic             fa_c;
   logic             accept;
   logic             last;

   assign accept = (state == IDLE) && start;
   assign last   = (cnt == CW'(WIDTH - 1));

   bit_full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (c_q),
      .s    (fa_s),
      .cout (fa_c)
   );

   // next-state decode
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (start) state_next = RUN;
         RUN:  if (last)  state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // state register with registered ready/done decodes
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state   <= state_next;
         ready_q <= (state_next == IDLE);
         done_q  <= (state_next == DONE);
      end
   end

   // operand load, serial shift, carry and overflow capture
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         a_sr    <= '0;
         b_sr    <= '0;
         res_sr  <= '0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         cnt  <= '0;
         a_sr <= a;
         b_sr <= (op == OP_SUB) ? ~b : b;
         c_q  <= (op == OP_SUB);
      end else if (state == RUN) begin
         a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
         res_sr  <= {fa_s, res_sr[WIDTH-1:1]};
         c_q     <= fa_c;
         carry_q <= fa_c;
         cnt     <= cnt + 1'b1;
         if (last) ovf_q <= c_q ^ fa_c;
      end
   end

   assign ready    = ready_q;
   assign done     = done_q;
   assign sum      = res_sr;
   assign carry    = carry_q;
   assign overflow = ovf_q;

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial N-bit adder/subtractor: the add-direction counterpart of the combinational 4-bit subtractor, with sequential control. Latches two operands on a start handshake and processes one bit per clock, LSB first, through a single full-adder cell and a carry flop. Reports sum, carry-out and signed overflow with a one-cycle done pulse. Used where area matters more than latency, and as the reference model that cross-checks the subtractor's results.

## Interface
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while ready=1.
- op  in  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- ready  out  1  high only in IDLE.
- done  out  1  single-cycle pulse when the result becomes valid.
- sum  out  WIDTH  result; held until the next accepted start.
- carry  out  1  carry-out of MSB. For subtract, 1 means a>=b unsigned (non-negative result), 0 means borrow.
- overflow  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1: latch a into shift register A, latch b (or ~b if op=1) into shift register B, set carry flop = op, clear bit counter, go to RUN.
- RUN: each cycle, the full adder combines A[0], B[0] and the carry flop. The sum bit shifts into the MSB of the result shift register, A and B shift right, the carry flop updates and the counter increments. At the bit WIDTH-1 cycle, capture the carry-in of that bit for overflow and go to DONE.
- DONE: done=1 for exactly one cycle; sum, carry and overflow are valid. Then go to IDLE.
- start while not IDLE: ignored; there is no queuing.
- start in the same cycle done is high: ignored, because ready=0 in DONE.
- All arithmetic is modulo 2^WIDTH. Subtract is a + ~b + 1, with the +1 supplied by the initial carry.
- Inputs a, b and op may change freely after the start cycle.
- Reset, including mid-RUN: state=IDLE, counter=0, all shift registers cleared, ready=1, done=0, sum=0, carry=0, overflow=0. A partial result is discarded.

## Timing
- Start sampled at edge E0.
- RUN occupies the cycles ending at edges E1..EWIDTH.
- State=DONE after EWIDTH. done is high between EWIDTH and EWIDTH+1.
- ready returns after EWIDTH+1.
- Latency start→done = WIDTH+1 edges. Throughput is one operation per WIDTH+2 cycles.
- sum, carry and overflow change only during RUN. They are stable from DONE until the next accepted start.
- The result register shifts during RUN. Consumers must sample only on done.
- ready is a registered decode of state, with no combinational path from start.

## Structure
- Package serial_add_sub_pkg:
  - state enum typedef {IDLE, RUN, DONE};
  - constants OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module bit_full_adder: a, b, cin → s, cout. It is purely combinational and instantiated once.
- Bit counter width is $clog2(WIDTH).

## Test plan
- WIDTH=4, op=ADD, a=0110, b=0101 → after 5 edges: done pulse, sum=1011, carry=0, overflow=1.
- op=SUB, a=0110, b=0101 → sum=0001, carry=1, overflow=0.
- op=ADD, a=1111, b=1111 → sum=1110, carry=1, overflow=0. op=SUB with the same operands → sum=0000, carry=1, overflow=0.
- op=SUB, a=0011, b=0111 → sum=1100, carry=0 (negative), overflow=0. The result must match the combinational subtractor for all 512 (a, b, op) combinations.
- Second start asserted 2 cycles into RUN with different operands → ignored. The first result completes unchanged and done pulses exactly once.
- rst asserted at RUN bit 2 → next cycle: ready=1, done=0, sum=0, carry=0, overflow=0. No done pulse follows; a new start completes normally.
